// File: rtl/static_reg_pkg.sv
// static_reg_pkg: shared state encoding and counter sizing for the static register bank
package static_reg_pkg;

    typedef enum logic [1:0] {SETTLE, LOCKED, ACK} state_t;

    function automatic int cnt_width(input int settle_cycles, input int scrub_period);
        return $clog2((settle_cycles > scrub_period ? settle_cycles : scrub_period) + 1);
    endfunction

endpackage

// File: rtl/static_reg_scrub.sv
// static_reg_scrub: periodic compare of locked words against live tie-offs with sticky drift flags
module static_reg_scrub
    import static_reg_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int NUM_CH       = 4,
    parameter int SCRUB_PERIOD = 256,
    parameter int CW           = cnt_width(1, SCRUB_PERIOD)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic [NUM_CH*WIDTH-1:0] live,
    input  logic [NUM_CH*WIDTH-1:0] locked,
    input  logic                    mismatch_clr,
    output logic [NUM_CH-1:0]       mismatch
);

    localparam logic [CW-1:0] LAST = CW'(SCRUB_PERIOD - 1);

    logic [CW-1:0]     cnt;
    logic              wrap;
    logic [NUM_CH-1:0] set;

    assign wrap = en && (cnt == LAST);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_cmp
        assign set[c] = wrap && (live[c*WIDTH +: WIDTH] != locked[c*WIDTH +: WIDTH]);
    end

    // period counter restarts whenever the bank leaves LOCKED; a set beats a same-edge clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt      <= '0;
            mismatch <= '0;
        end else begin
            cnt      <= (en && !wrap) ? cnt + 1'b1 : '0;
            mismatch <= (mismatch & ~{NUM_CH{mismatch_clr}}) | set;
        end
    end

endmodule

// File: rtl/static_reg_bank.sv
// static_reg_bank: captures tie-off words after a settle delay, locks them, supports recapture and scrub
module static_reg_bank
    import static_reg_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int NUM_CH        = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter bit SCRUB_EN      = 1,
    parameter int SCRUB_PERIOD  = 256
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH*WIDTH-1:0] static_i,
    input  logic                    recap_req,
    input  logic                    mismatch_clr,
    output logic [NUM_CH*WIDTH-1:0] static_o,
    output logic                    static_valid,
    output logic                    recap_ack,
    output logic [NUM_CH-1:0]       mismatch
);

    localparam int            CW          = cnt_width(SETTLE_CYCLES, SCRUB_PERIOD);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES);

    state_t                  state, state_nx;
    logic [CW-1:0]           cnt, cnt_nx;
    logic                    recap, recap_nx;
    logic [NUM_CH*WIDTH-1:0] static_nx;
    logic                    valid_nx, ack_nx;

    // register the whole control/data state; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= SETTLE;
            cnt          <= '0;
            recap        <= 1'b0;
            static_o     <= '0;
            static_valid <= 1'b0;
            recap_ack    <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            recap        <= recap_nx;
            static_o     <= static_nx;
            static_valid <= valid_nx;
            recap_ack    <= ack_nx;
        end
    end

    // settle count then capture; recapture re-enters SETTLE and finishes through the ACK handshake
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        recap_nx  = recap;
        static_nx = static_o;
        valid_nx  = static_valid;
        ack_nx    = recap_ack;
        case (state)
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    static_nx = static_i;
                    valid_nx  = 1'b1;
                    cnt_nx    = '0;
                    ack_nx    = recap;
                    state_nx  = recap ? ACK : LOCKED;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            LOCKED: begin
                if (recap_req) begin
                    state_nx = SETTLE;
                    recap_nx = 1'b1;
                    valid_nx = 1'b0;
                end
            end
            ACK: begin
                if (!recap_req) begin
                    ack_nx   = 1'b0;
                    recap_nx = 1'b0;
                    state_nx = LOCKED;
                end
            end
            default: state_nx = SETTLE;
        endcase
    end

    if (SCRUB_EN) begin : g_scrub
        static_reg_scrub #(
            .WIDTH       (WIDTH),
            .NUM_CH      (NUM_CH),
            .SCRUB_PERIOD(SCRUB_PERIOD),
            .CW          (CW)
        ) u_scrub (
            .clk         (clk),
            .reset_n     (reset_n),
            .en          (state == LOCKED),
            .live        (static_i),
            .locked      (static_o),
            .mismatch_clr(mismatch_clr),
            .mismatch    (mismatch)
        );
    end else begin : g_no_scrub
        logic unused_clr;
        assign unused_clr = mismatch_clr;
        assign mismatch   = '0;
    end

endmodule

// File: tb/tb_static_reg_bank.sv
// tb_static_reg_bank: directed and randomized checks of static_reg_bank against a behavioural model
module tb_static_reg_bank;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        recap_req = 1'b0;
    logic        mismatch_clr = 1'b0;
    logic [31:0] static_i = '0;
    logic [31:0] static_o;
    logic        static_valid, recap_ack;
    logic [3:0]  mismatch;
    logic [0:0]  static_o1;
    logic        valid1, ack1;
    logic [0:0]  mismatch1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    static_reg_bank #(
        .WIDTH(8), .NUM_CH(4), .SETTLE_CYCLES(4), .SCRUB_EN(1), .SCRUB_PERIOD(256)
    ) dut (
        .clk(clk), .reset_n(reset_n), .static_i(static_i), .recap_req(recap_req),
        .mismatch_clr(mismatch_clr), .static_o(static_o), .static_valid(static_valid),
        .recap_ack(recap_ack), .mismatch(mismatch)
    );

    static_reg_bank #(
        .WIDTH(1), .NUM_CH(1), .SETTLE_CYCLES(4), .SCRUB_EN(0), .SCRUB_PERIOD(256)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .static_i(static_i[0]), .recap_req(recap_req),
        .mismatch_clr(mismatch_clr), .static_o(static_o1), .static_valid(valid1),
        .recap_ack(ack1), .mismatch(mismatch1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // behavioural model: edges spent settling / locked, pending recapture, ack phase
    bit          model_ok = 0;
    int          settle_n, lock_n;
    bit          locked, acking, pend;
    logic [31:0] m_o;
    bit          m_v, m_a;
    logic [3:0]  m_mm, hit;

    always @(posedge clk) begin
        if (!reset_n) begin
            settle_n = 0; lock_n = 0; locked = 0; acking = 0; pend = 0;
            m_o = '0; m_v = 0; m_a = 0; m_mm = '0; model_ok = 1;
        end else begin
            hit = '0;
            if (locked && (lock_n % 256) == 255)
                for (int c = 0; c < 4; c++)
                    hit[c] = (static_i[c*8 +: 8] != m_o[c*8 +: 8]);
            m_mm = (mismatch_clr ? 4'h0 : m_mm) | hit;
            if (locked) begin
                lock_n++;
                if (recap_req) begin
                    locked = 0; pend = 1; settle_n = 0; m_v = 0;
                end
            end else if (acking) begin
                if (!recap_req) begin
                    acking = 0; m_a = 0; pend = 0; locked = 1; lock_n = 0;
                end
            end else if (settle_n == 4) begin
                m_o = static_i; m_v = 1; settle_n = 0;
                if (pend) begin
                    acking = 1; m_a = 1;
                end else begin
                    locked = 1; lock_n = 0;
                end
            end else begin
                settle_n++;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("static_o", static_o, m_o);
            chk("static_valid", 32'(static_valid), 32'(m_v));
            chk("recap_ack", 32'(recap_ack), 32'(m_a));
            chk("mismatch", 32'(mismatch), 32'(m_mm));
            chk("ch1_static_o", 32'(static_o1), 32'(m_o[0]));
            chk("ch1_valid", 32'(valid1), 32'(m_v));
            chk("ch1_ack", 32'(ack1), 32'(m_a));
            chk("ch1_mismatch", 32'(mismatch1), 32'h0);
        end
    end

    initial begin
        static_i = 32'h44332211;
        tick; tick;
        reset_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick;
            chk("init_valid_low", 32'(static_valid), 32'h0);
            chk("init_ch1_valid_low", 32'(valid1), 32'h0);
        end
        tick;
        chk("init_capture", static_o, 32'h44332211);
        chk("init_valid", 32'(static_valid), 32'h1);
        chk("init_ch1_capture", 32'(static_o1), 32'h1);
        chk("init_ch1_valid", 32'(valid1), 32'h1);

        static_i = 32'h44332299;
        for (int i = 0; i < 300 && mismatch == 4'h0; i++) tick;
        chk("scrub_set", 32'(mismatch), 32'h1);
        chk("scrub_keeps_o", static_o, 32'h44332211);
        mismatch_clr = 1'b1; tick; mismatch_clr = 1'b0;
        chk("clr_nonwrap", 32'(mismatch), 32'h0);
        repeat (254) tick;
        mismatch_clr = 1'b1; tick; mismatch_clr = 1'b0;
        chk("set_beats_clr", 32'(mismatch), 32'h1);

        static_i  = 32'hAABBCCDD;
        recap_req = 1'b1;
        tick;
        chk("recap_valid_drop", 32'(static_valid), 32'h0);
        chk("recap_old_o", static_o, 32'h44332211);
        for (int i = 1; i <= 4; i++) begin
            tick;
            chk("recap_settle_valid", 32'(static_valid), 32'h0);
            chk("recap_settle_ack", 32'(recap_ack), 32'h0);
        end
        tick;
        chk("recap_capture", static_o, 32'hAABBCCDD);
        chk("recap_valid", 32'(static_valid), 32'h1);
        chk("recap_ack_high", 32'(recap_ack), 32'h1);
        repeat (3) begin
            tick;
            chk("recap_ack_hold", 32'(recap_ack), 32'h1);
        end
        recap_req = 1'b0;
        tick;
        chk("recap_ack_low", 32'(recap_ack), 32'h0);
        chk("recap_valid_kept", 32'(static_valid), 32'h1);

        reset_n = 1'b0; recap_req = 1'b1;
        tick;
        chk("reset_mismatch", 32'(mismatch), 32'h0);
        chk("reset_o", static_o, 32'h0);
        tick;
        reset_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick;
            chk("held_init_valid", 32'(static_valid), 32'h0);
            chk("held_init_ack", 32'(recap_ack), 32'h0);
        end
        tick;
        chk("held_first_valid", 32'(static_valid), 32'h1);
        chk("held_first_ack", 32'(recap_ack), 32'h0);
        tick;
        chk("held_second_settle", 32'(static_valid), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            tick;
            chk("held_no_early_ack", 32'(recap_ack), 32'h0);
        end
        tick;
        chk("held_second_ack", 32'(recap_ack), 32'h1);
        chk("held_second_valid", 32'(static_valid), 32'h1);
        recap_req = 1'b0;
        tick;
        chk("held_ack_low", 32'(recap_ack), 32'h0);

        recap_req = 1'b1;
        tick; tick; tick;
        reset_n = 1'b0;
        tick;
        chk("midrecap_o", static_o, 32'h0);
        chk("midrecap_valid", 32'(static_valid), 32'h0);
        chk("midrecap_ack", 32'(recap_ack), 32'h0);
        chk("midrecap_mm", 32'(mismatch), 32'h0);
        reset_n = 1'b1; recap_req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick;
            chk("restart_valid_low", 32'(static_valid), 32'h0);
        end
        tick;
        chk("restart_valid", 32'(static_valid), 32'h1);
        chk("restart_capture", static_o, 32'hAABBCCDD);

        repeat (4000) begin
            if ($urandom_range(0, 7) == 0) static_i = $urandom;
            if ($urandom_range(0, 199) == 0) recap_req = ~recap_req;
            mismatch_clr = ($urandom_range(0, 29) == 0);
            reset_n = ($urandom_range(0, 499) != 0);
            tick;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
